// File: rtl/prio_enc_rr_pkg.sv
// Shared constants, FSM state type and sizing helper for the round-robin
// priority encoder.
package prio_enc_rr_pkg;

  localparam int unsigned PE_FIXED = 0;
  localparam int unsigned PE_RR    = 1;

  typedef enum logic [0:0] {
    StIdle,
    StServe
  } pe_state_e;

  function automatic int unsigned pe_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_enc_rr_pick.sv
// Combinational winner search: first set bit of vec scanning downward from
// start, wrapping from index 0 to WIDTH-1.
module prio_pick
  import prio_enc_rr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IW    = pe_clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  input  logic [IW-1:0]    start,
  output logic [IW-1:0]    idx,
  output logic [WIDTH-1:0] onehot,
  output logic             any
);

  always_comb begin
    int unsigned jj;
    logic [IW-1:0] j;
    idx = '0;
    any = 1'b0;
    jj  = 0;
    j   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      // start is always < WIDTH, so one conditional add gives the wrap
      jj = (i <= 32'(start)) ? 32'(start) - i : 32'(start) + WIDTH - i;
      j  = IW'(jj);
      if (!any && vec[j]) begin
        any = 1'b1;
        idx = j;
      end
    end
    onehot = any ? (WIDTH'(1) << idx) : '0;
  end

endmodule

// File: rtl/prio_enc_rr.sv
// Priority encoder that captures a request vector and issues one grant per
// accepted handshake, in fixed-priority or round-robin order.
module prio_enc_rr
  import prio_enc_rr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MODE  = PE_FIXED,
  localparam int unsigned IW   = (pe_clog2(WIDTH) > 1) ? pe_clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             req_valid,
  output logic             req_ready,
  output logic [IW-1:0]    grant_idx,
  output logic [WIDTH-1:0] grant_onehot,
  output logic             grant_valid,
  input  logic             grant_ready,
  output logic [IW:0]      pending_cnt
);

  localparam logic [IW-1:0] PtrMax = IW'(WIDTH - 1);

  pe_state_e        state_q;
  logic [WIDTH-1:0] pending_q;
  logic [IW-1:0]    ptr_q;

  logic [IW-1:0]    start;
  logic [IW-1:0]    pick_idx;
  logic [WIDTH-1:0] pick_oh;
  logic             pick_any;
  logic [WIDTH-1:0] pending_clr;

  // Fixed priority is just a search that always starts at the top index.
  assign start = (MODE == PE_RR) ? ptr_q : PtrMax;

  prio_pick #(
    .WIDTH(WIDTH),
    .IW   (IW)
  ) u_pick (
    .vec   (pending_q),
    .start (start),
    .idx   (pick_idx),
    .onehot(pick_oh),
    .any   (pick_any)
  );

  assign pending_clr = pending_q & ~pick_oh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      ptr_q     <= PtrMax;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            pending_q <= req;
            if (|req) state_q <= StServe;
          end
        end
        StServe: begin
          if (grant_ready) begin
            pending_q <= pending_clr;
            if (MODE == PE_RR) begin
              ptr_q <= (pick_idx == '0) ? PtrMax : pick_idx - IW'(1);
            end
            if (pending_clr == '0) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // All outputs derive from state only, so handshakes never loop back here.
  always_comb begin
    grant_valid  = (state_q == StServe);
    req_ready    = (state_q == StIdle) && !rst;
    grant_idx    = (grant_valid && pick_any) ? pick_idx : '0;
    grant_onehot = grant_valid ? pick_oh : '0;
    pending_cnt  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pending_cnt = pending_cnt + {{IW{1'b0}}, pending_q[i]};
    end
  end

endmodule

// File: doc/prio_enc_rr.md
PRIO_ENC_RR -- requirements
Module: prio_enc_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the request vector width; legal range 2..64.
REQ-002 SHALL have parameter MODE, default 0, meaning 0 = fixed priority (highest index wins) and 1 = round-robin.
REQ-003 SHALL derive IW = max(1, ceil(log2(WIDTH))) as the index width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req, input, WIDTH bits: request vector, sampled on acceptance.
REQ-007 SHALL have port req_valid, input, 1 bit: req is valid.
REQ-008 SHALL have port req_ready, output, 1 bit: the block can accept a vector.
REQ-009 SHALL have port grant_idx, output, IW bits: binary index of the current winner.
REQ-010 SHALL have port grant_onehot, output, WIDTH bits: one-hot form of grant_idx.
REQ-011 SHALL have port grant_valid, output, 1 bit: grant_idx and grant_onehot are meaningful.
REQ-012 SHALL have port grant_ready, input, 1 bit: the consumer accepts the grant.
REQ-013 SHALL have port pending_cnt, output, IW+1 bits: population count of the pending register.

Function
REQ-014 SHALL hold a WIDTH-bit pending register and an IW-bit search pointer ptr.
REQ-015 SHALL use a two-state FSM: IDLE (pending==0) and SERVE (pending!=0).
REQ-016 SHALL drive req_ready=1 only in IDLE with rst low; there is no combinational path from req_valid or grant_ready to any output.
REQ-017 SHALL, in IDLE, load pending<=req on req_valid&&req_ready; a nonzero vector moves the FSM to SERVE, a zero vector is consumed and the FSM stays in IDLE.
REQ-018 SHALL raise grant_valid in the cycle after a nonzero vector is accepted (latency 1), and hold it high throughout SERVE.
REQ-019 SHALL, in MODE 0, grant the highest set index of pending.
REQ-020 SHALL, in MODE 1, grant the first set bit found scanning downward from ptr, wrapping from index 0 to index WIDTH-1.
REQ-021 SHALL hold grant_idx, grant_onehot and pending stable while grant_valid && !grant_ready.
REQ-022 SHALL, on grant_valid&&grant_ready, clear the granted bit of pending, and in MODE 1 set ptr <= (grant_idx-1) mod WIDTH.
REQ-023 SHALL issue one grant per cycle under continuous grant_ready=1, so a vector with k set bits drains in k cycles.
REQ-024 SHALL return to IDLE on the edge that clears the last pending bit; req_ready rises in the following cycle (one bubble cycle).
REQ-025 SHALL leave ptr unchanged in MODE 0 and keep it persistent across vectors in MODE 1.
REQ-026 SHALL drive grant_idx=0 and grant_onehot=0 whenever grant_valid=0.
REQ-027 SHALL keep pending_cnt equal to popcount(pending) every cycle.
REQ-028 SHALL handle non-power-of-two WIDTH: indices >= WIDTH are never granted, and the wrap goes to WIDTH-1.

Reset
REQ-029 SHALL, on rst assertion, immediately clear pending to 0, set ptr to WIDTH-1 and force the FSM to IDLE.
REQ-030 SHALL, while rst is high, drive req_ready=0, grant_valid=0, grant_idx=0, grant_onehot=0 and pending_cnt=0.
REQ-031 SHALL, on reset asserted mid-drain, discard any in-flight grant; after rst falls the first cycle shows req_ready=1 and nothing is replayed.

Structure
REQ-032 SHALL place in the shared package the mode constants PE_FIXED=0 and PE_RR=1 plus a clog2 helper function.
REQ-033 SHALL implement the winner search as one combinational sub-module prio_pick (inputs vec and start, outputs idx, onehot, any) instantiated once.

Verification
REQ-034 SHALL cover: WIDTH=8, MODE 0, req=8'b1010_0100, grant_ready=1 -> grant_idx 7,5,2 on three consecutive cycles starting 1 cycle after acceptance; req_ready=1 on the 4th cycle after acceptance (one bubble cycle after the drain).
REQ-035 SHALL cover: WIDTH=8, MODE 1, first vector 8'b0000_0100 drained (ptr becomes 1), then 8'b1000_0001 -> grants 0 then 7.
REQ-036 SHALL cover: grant_ready held at 0 for 3 cycles with req=8'h81 in MODE 0 -> grant_idx=7 stable and pending_cnt=2 throughout; release -> 7 then 0.
REQ-037 SHALL cover: req=8'h00 accepted -> grant_valid stays 0 and req_ready stays 1 in the next cycle.
REQ-038 SHALL cover: rst pulsed after the first grant of 8'hFF -> all outputs 0 immediately, req_ready=1 in the first cycle after release, pending_cnt=0.
REQ-039 SHALL cover: WIDTH=5, MODE 1, ptr=0, req=5'b10010 -> grant 4 first, then 1; index 5..7 never asserted.
